// File: rtl/sevenseg_scan_decoder_pkg.sv
// Shared definitions for the seven-segment score display encoder and its
// loopback scan decoder: glyph patterns, digit positions and the runs limit.
package sevenseg_scan_decoder_pkg;

  // Active-low segment patterns, ordered g,f,e,d,c,b,a.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit positions on the display (index into the an bus).
  localparam int DIG_RUNS_H = 3;
  localparam int DIG_RUNS_T = 2;
  localparam int DIG_RUNS_U = 1;
  localparam int DIG_WKT    = 0;

  localparam int RUNS_MAX = 255;

  // How many digits the current anode pattern selects.
  typedef enum logic [1:0] {
    AN_BLANK,
    AN_SINGLE,
    AN_MULTI
  } an_kind_e;

  function automatic an_kind_e classify_an(input logic [3:0] an);
    int unsigned lows;
    lows = $countones(~an);
    if (lows == 0)      return AN_BLANK;
    else if (lows == 1) return AN_SINGLE;
    else                return AN_MULTI;
  endfunction

  // Position of the (single) low anode bit; 0 when none is low.
  function automatic logic [1:0] an_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder: active-low gfedcba pattern to BCD digit.
// Anything outside the ten digit glyphs (blank, letters) is reported invalid.
module seg_glyph_decode
  import sevenseg_scan_decoder_pkg::*;
(
  input  logic [6:0] ca,
  output logic [3:0] bcd,
  output logic       valid
);

  // Table lookup from segment pattern to digit value.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    bcd   = 4'd0;
    valid = 1'b1;
    case (ca)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Observes the multiplexed an/ca/dp display drive, samples each digit once it
// has settled, and commits complete legal frames as BCD digits, runs, wickets.
module sevenseg_scan_decoder
  import sevenseg_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk_fpga,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  ca,
  input  logic        dp,
  output logic [15:0] digits,
  output logic [7:0]  runs,
  output logic [3:0]  wickets,
  output logic [3:0]  dp_mask,
  output logic        frame_valid,
  output logic        frame_stable,
  output logic        glyph_err,
  output logic        scan_lost
);

  localparam int DW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] DWELL_SAT     = DW'(SETTLE_CYCLES);
  localparam logic [DW-1:0] DWELL_CAPTURE = DW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_SAT   = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]      an_r, an_d;
  logic [6:0]      ca_r;
  logic            dp_r;
  logic            an_chg;
  logic [DW-1:0]   dwell_cnt;
  logic [TW-1:0]   timeout_cnt;
  an_kind_e        an_kind;
  logic [1:0]      cap_idx;
  logic [3:0]      dec_bcd;
  logic            dec_valid;
  logic            capture;
  logic [3:0]      captured, captured_next;
  logic [3:0][3:0] bcd_cap;
  logic [3:0]      valid_cap;
  logic [3:0]      dp_cap;
  logic            commit;
  logic [9:0]      runs_calc;
  logic            frame_ok;

  seg_glyph_decode u_decode (
    .ca    (ca_r),
    .bcd   (dec_bcd),
    .valid (dec_valid)
  );

  // Register the display drive once; an_d holds the previous anode pattern.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      an_r <= 4'b1111;
      an_d <= 4'b1111;
      ca_r <= SEG_BLANK;
      dp_r <= 1'b1;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      an_r <= an;
      an_d <= an_r;
      ca_r <= ca;
      dp_r <= dp;
    end
  end

  assign an_chg  = (an_r != an_d);
  assign an_kind = classify_an(an_r);
  assign cap_idx = an_index(an_r);
  assign capture = !an_chg && (dwell_cnt == DWELL_CAPTURE) && (an_kind == AN_SINGLE);
  assign commit  = (captured == 4'b1111);

  // Dwell and stall counters restart on any anode change and saturate.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      dwell_cnt   <= '0;
      timeout_cnt <= '0;
      scan_lost   <= 1'b0;
    end else if (an_chg) begin
      dwell_cnt   <= '0;
      timeout_cnt <= '0;
      scan_lost   <= 1'b0;
    end else begin
      if (dwell_cnt != DWELL_SAT) dwell_cnt <= dwell_cnt + 1'b1;
      if (timeout_cnt != TIMEOUT_SAT) timeout_cnt <= timeout_cnt + 1'b1;
      else scan_lost <= 1'b1;
    end
  end

  // Frame bookkeeping: commit, stall or a multi-digit anode empties the frame;
  // a capture in the same cycle lands in the emptied frame.
  always_comb begin
    captured_next = captured;
    if (commit || scan_lost || an_kind == AN_MULTI) captured_next = '0;
    if (capture) captured_next[cap_idx] = 1'b1;
  end

  // Captured-digit flags.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) captured <= '0;
    else       captured <= captured_next;
  end

  // Per-digit capture storage; latest capture of a digit wins.
  // NOTE: no reset on these data registers; they are only read once all four captured flags are set.
  always_ff @(posedge clk_fpga) begin
    if (capture) begin
      bcd_cap[cap_idx]   <= dec_bcd;
      valid_cap[cap_idx] <= dec_valid;
      dp_cap[cap_idx]    <= ~dp_r;
    end
  end

  // Full-width runs value so the range check sees the untruncated sum.
  assign runs_calc = 10'(bcd_cap[DIG_RUNS_H]) * 10'd100
                   + 10'(bcd_cap[DIG_RUNS_T]) * 10'd10
                   + 10'(bcd_cap[DIG_RUNS_U]);
  assign frame_ok  = (&valid_cap) && (runs_calc <= 10'(RUNS_MAX));

  // Commit or reject a complete frame and track frame-to-frame stability.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      digits       <= '0;
      runs         <= '0;
      wickets      <= '0;
      dp_mask      <= '0;
      frame_valid  <= 1'b0;
      frame_stable <= 1'b0;
      glyph_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      glyph_err   <= 1'b0;
      if (commit) begin
        if (frame_ok) begin
          digits       <= bcd_cap;
          runs         <= runs_calc[7:0];
          wickets      <= bcd_cap[DIG_WKT];
          dp_mask      <= dp_cap;
          frame_valid  <= 1'b1;
          frame_stable <= ({bcd_cap, dp_cap} == {digits, dp_mask});
        end else begin
          glyph_err    <= 1'b1;
          frame_stable <= 1'b0;
        end
      end
    end
  end

endmodule
